// File: rtl/serial_master_pkg.sv
// Shared frame geometry and FSM state encoding for the serial master.
package serial_master_pkg;

  localparam int unsigned FRAME_BITS = 40;
  localparam int unsigned HDR_BITS   = 8;
  localparam int unsigned DATA_BITS  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/serial_tick_gen.sv
// Half-period tick generator: o_tick fires on the last cycle of each
// CLK_DIV-cycle phase while enabled. i_load restarts the phase.
module serial_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic i_en,
  input  logic i_load,
  output logic o_tick
);

  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] r_cnt;

  // Down-counter reloaded at every phase boundary, parks at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 8'd1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/serial_master.sv
// Serial register-access master: shifts a 40-bit {rw, addr, wdata} frame
// MSB first and captures 32 read-data bits from sdi.
module serial_master
  import serial_master_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        sen,
  output logic        sclk,
  output logic        sdo,
  input  logic        sdi
);

  state_t                  r_state;
  state_t                  w_next;
  logic                    r_phase;   // 1 = sclk high phase of current bit
  logic [5:0]              r_bitcnt;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]    r_cap;
  logic [DATA_BITS-1:0]    r_rdata;
  logic                    r_rw;
  logic                    r_done;

  logic w_accept;
  logic w_busy;
  logic w_tick;
  logic w_load;

  assign w_busy   = (r_state != ST_IDLE);
  assign w_accept = start && !w_busy;
  assign w_load   = w_accept || w_tick;

  serial_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .i_en   (w_busy),
    .i_load (w_load),
    .o_tick (w_tick)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: every phase transition happens on a tick.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_SETUP;
      ST_SETUP: if (w_tick) w_next = ST_SHIFT;
      ST_SHIFT: if (w_tick && !r_phase && (r_bitcnt == '0)) w_next = ST_HOLD;
      ST_HOLD:  if (w_tick) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath: frame load, bit shifting, read capture and completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_phase  <= 1'b0;
      r_bitcnt <= '0;
      r_shift  <= '0;
      r_cap    <= '0;
      r_rdata  <= '0;
      r_rw     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_shift  <= {rw, addr, wdata};
            r_rw     <= rw;
            r_bitcnt <= 6'(FRAME_BITS - 1);
            r_phase  <= 1'b0;
          end
        end
        ST_SETUP: begin
          if (w_tick) r_phase <= 1'b1;
        end
        ST_SHIFT: begin
          if (w_tick) begin
            if (r_phase) begin
              // Last cycle of the high phase: sample the slave.
              r_phase <= 1'b0;
              if (r_rw && (r_bitcnt < 6'(DATA_BITS))) begin
                r_cap <= {r_cap[DATA_BITS-2:0], sdi};
              end
            end else if (r_bitcnt != '0) begin
              // Falling sclk edge: present the next frame bit.
              r_bitcnt <= r_bitcnt - 6'd1;
              r_shift  <= {r_shift[FRAME_BITS-2:0], 1'b0};
              r_phase  <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (w_tick) begin
            r_done <= 1'b1;
            if (r_rw) r_rdata <= r_cap;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from state and datapath registers.
  always_comb begin
    busy  = w_busy;
    done  = r_done;
    rdata = r_rdata;
    sen   = !w_busy;
    sclk  = (r_state == ST_SHIFT) && r_phase;
    sdo   = w_busy && r_shift[FRAME_BITS-1];
  end

endmodule

// File: tb/tb_serial_master.sv
// Scoreboard bench for serial_master: CLK_DIV=4 and CLK_DIV=1 instances,
// each with a behavioural slave that records the frame and drives sdi.
module tb_serial_master;

  typedef struct {
    logic        rd;
    logic [39:0] frame;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic sdi_bit(logic [31:0] ret, int n);
    if (n >= 9 && n <= 40) return ret[40-n];
    return 1'b0;
  endfunction

  // ---------------- CLK_DIV = 4 instance ----------------
  logic        rst4, start4, rw4, sdi4;
  logic [6:0]  addr4;
  logic [31:0] wdata4, ret4;
  logic        busy4, done4, sen4, sclk4, sdo4;
  logic [31:0] rdata4;

  serial_master #(.CLK_DIV(4)) u4 (
    .clock(clk), .reset(rst4), .start(start4), .rw(rw4), .addr(addr4),
    .wdata(wdata4), .busy(busy4), .done(done4), .rdata(rdata4),
    .sen(sen4), .sclk(sclk4), .sdo(sdo4), .sdi(sdi4)
  );

  logic [39:0] rx4 = '0, last4 = '0;
  int          rxn4 = 0, lastn4 = 0;
  always @(negedge sen4) rxn4 = 0;
  always @(posedge sclk4) if (!sen4) begin rx4 = {rx4[38:0], sdo4}; rxn4++; end
  always @(posedge sen4) begin last4 = rx4; lastn4 = rxn4; end
  assign sdi4 = sdi_bit(ret4, rxn4);

  // ---------------- CLK_DIV = 1 instance ----------------
  logic        rst1, start1, rw1, sdi1;
  logic [6:0]  addr1;
  logic [31:0] wdata1, ret1;
  logic        busy1, done1, sen1, sclk1, sdo1;
  logic [31:0] rdata1;

  serial_master #(.CLK_DIV(1)) u1 (
    .clock(clk), .reset(rst1), .start(start1), .rw(rw1), .addr(addr1),
    .wdata(wdata1), .busy(busy1), .done(done1), .rdata(rdata1),
    .sen(sen1), .sclk(sclk1), .sdo(sdo1), .sdi(sdi1)
  );

  logic [39:0] rx1 = '0, last1 = '0;
  int          rxn1 = 0, lastn1 = 0;
  always @(negedge sen1) rxn1 = 0;
  always @(posedge sclk1) if (!sen1) begin rx1 = {rx1[38:0], sdo1}; rxn1++; end
  always @(posedge sen1) begin last1 = rx1; lastn1 = rxn1; end
  assign sdi1 = sdi_bit(ret1, rxn1);

  // ---------------- scoreboards and monitors ----------------
  exp_t q4[$];
  exp_t q1[$];
  exp_t e4, e1;
  int   busyn4 = 0, busyn1 = 0;
  int   sdo_bad = 0;

  always @(negedge clk) begin
    if (rst4) busyn4 = 0; else if (busy4) busyn4++;
    if (sen4 && sdo4) sdo_bad++;
    if (done4) begin
      if (q4.size() == 0) begin
        chk("u4_unexpected_done", 1, 0);
      end else begin
        e4 = q4.pop_front();
        chk("u4_rdata", rdata4, e4.rdata);
        if (e4.rd) chk("u4_header", last4[39:32], e4.frame[39:32]);
        else       chk("u4_frame", last4, e4.frame);
        chk("u4_bits", lastn4, 40);
        chk("u4_done_cycle", cyc, e4.cyc);
        chk("u4_busy_cycles", busyn4, 328);
      end
      busyn4 = 0;
    end
  end

  always @(negedge clk) begin
    if (rst1) busyn1 = 0; else if (busy1) busyn1++;
    if (sen1 && sdo1) sdo_bad++;
    if (done1) begin
      if (q1.size() == 0) begin
        chk("u1_unexpected_done", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("u1_rdata", rdata1, e1.rdata);
        if (e1.rd) chk("u1_header", last1[39:32], e1.frame[39:32]);
        else       chk("u1_frame", last1, e1.frame);
        chk("u1_bits", lastn1, 40);
        chk("u1_done_cycle", cyc, e1.cyc);
        chk("u1_busy_cycles", busyn1, 82);
      end
      busyn1 = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  int unsigned scyc;

  task automatic txn4(input logic r, input logic [6:0] a, input logic [31:0] w,
                      input logic [31:0] ret, input logic [39:0] xframe,
                      input logic [31:0] xrdata, input logic push);
    exp_t e;
    @(posedge clk); #1;
    start4 = 1'b1; rw4 = r; addr4 = a; wdata4 = w; ret4 = ret;
    scyc = cyc;
    if (push) begin
      e.rd = r; e.frame = xframe; e.rdata = xrdata; e.cyc = scyc + 329;
      q4.push_back(e);
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    @(negedge clk);
    chk("u4_first_busy", busy4, 1);
    chk("u4_first_sen", sen4, 0);
    chk("u4_first_sdo", sdo4, r);
  endtask

  task automatic wait_done4();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done4 && n < 1000);
    if (!done4) chk("u4_done_timeout", 0, 1);
  endtask

  task automatic wait_done1();
    int n = 0;
    do begin @(negedge clk); n++; end while (!done1 && n < 300);
    if (!done1) chk("u1_done_timeout", 0, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    exp_t e;
    rst4 = 1'b1; rst1 = 1'b1; start4 = 1'b0; start1 = 1'b0;
    rw4 = 1'b0; rw1 = 1'b0; addr4 = '0; addr1 = '0;
    wdata4 = '0; wdata1 = '0; ret4 = '0; ret1 = '0;

    // Start held together with reset must not launch a frame.
    repeat (2) @(posedge clk);
    #1 start4 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0; rst1 = 1'b0; start4 = 1'b0; start1 = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_sen", sen4, 1);
    chk("rst_sclk", sclk4, 0);
    chk("rst_sdo", sdo4, 0);
    chk("rst_done", done4, 0);
    chk("rst_rdata", rdata4, 0);
    chk("rst_u1_busy", busy1, 0);
    chk("rst_u1_sen", sen1, 1);

    // Write 0x05 <- DEADBEEF.
    txn4(1'b0, 7'h05, 32'hDEADBEEF, 32'h0, 40'h05DEADBEEF, 32'h0, 1'b1);
    wait_done4();

    // Read 0x2A, slave returns F0F0931A; header on the wire is AA.
    txn4(1'b1, 7'h2A, 32'h0, 32'hF0F0931A, 40'hAA00000000, 32'hF0F0931A, 1'b1);
    wait_done4();

    // Write leaves rdata at its previous read value.
    txn4(1'b0, 7'h11, 32'h12345678, 32'hFFFFFFFF, 40'h1112345678, 32'hF0F0931A, 1'b1);
    wait_done4();

    // Second start at cycle 100 of a write is ignored.
    txn4(1'b0, 7'h40, 32'h0BADF00D, 32'h0, 40'h400BADF00D, 32'hF0F0931A, 1'b1);
    repeat (99) @(posedge clk);
    #1 start4 = 1'b1; rw4 = 1'b1; addr4 = 7'h7F; wdata4 = 32'hFFFFFFFF;
    @(posedge clk); #1 start4 = 1'b0;
    wait_done4();
    repeat (400) @(negedge clk);

    // Reset at cycle 150 of a read aborts it.
    txn4(1'b1, 7'h2A, 32'h0, 32'hF0F0931A, 40'h0, 32'h0, 1'b0);
    repeat (149) @(posedge clk);
    #1 rst4 = 1'b1;
    @(posedge clk); #1 rst4 = 1'b0;
    @(negedge clk);
    chk("abort_sen", sen4, 1);
    chk("abort_sclk", sclk4, 0);
    chk("abort_busy", busy4, 0);
    chk("abort_rdata", rdata4, 0);
    repeat (400) @(negedge clk);
    chk("abort_rdata_later", rdata4, 0);

    // CLK_DIV=1: write, then read started in the done cycle.
    @(posedge clk); #1;
    start1 = 1'b1; rw1 = 1'b0; addr1 = 7'h33; wdata1 = 32'hA5A5A5A5;
    e.rd = 1'b0; e.frame = 40'h33A5A5A5A5; e.rdata = 32'h0; e.cyc = cyc + 83;
    q1.push_back(e);
    @(posedge clk); #1 start1 = 1'b0;
    wait_done1();
    start1 = 1'b1; rw1 = 1'b1; addr1 = 7'h01; wdata1 = 32'h0; ret1 = 32'h00000001;
    e.rd = 1'b1; e.frame = 40'h8100000000; e.rdata = 32'h00000001; e.cyc = cyc + 83;
    q1.push_back(e);
    chk("b2b_gap_sen_high", sen1, 1);
    @(posedge clk); #1 start1 = 1'b0;
    @(negedge clk);
    chk("b2b_second_sen_low", sen1, 0);
    chk("b2b_second_busy", busy1, 1);
    wait_done1();
    repeat (20) @(negedge clk);

    chk("sdo_low_while_sen_high", sdo_bad, 0);
    chk("u4_queue_drained", q4.size(), 0);
    chk("u1_queue_drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_master.md
SERIAL_MASTER -- requirements
Module: serial_master

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the SCLK half-period in clock cycles (legal range 1..255).
REQ-002 The block SHALL have port clock, input, 1 bit: sole clock, rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: single-cycle request to begin a transaction.
REQ-005 The block SHALL have port rw, input, 1 bit: 1 means read, 0 means write; sampled with start.
REQ-006 The block SHALL have port addr, input, 7 bits: register address; sampled with start.
REQ-007 The block SHALL have port wdata, input, 32 bits: write payload; sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: transaction in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 The block SHALL have port rdata, output, 32 bits: last read result.
REQ-011 The block SHALL have port sen, output, 1 bit: active-low slave enable.
REQ-012 The block SHALL have port sclk, output, 1 bit: serial clock, idles low.
REQ-013 The block SHALL have port sdo, output, 1 bit: serial data to the slave.
REQ-014 The block SHALL have port sdi, input, 1 bit: serial data from the slave.

Function
REQ-015 The frame SHALL be 40 bits, MSB first: bit 39 = rw, bits 38:32 = addr, bits 31:0 = wdata (write) or don't-care (read).
REQ-016 A start while busy=0 SHALL be accepted; a start while busy=1 SHALL be ignored without corrupting the active frame.
REQ-017 States SHALL be IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
REQ-018 In the cycle after an accepted start: busy=1, sen=0, sdo=frame bit 39, state=SETUP.
REQ-019 SETUP SHALL last CLK_DIV cycles with sclk=0.
REQ-020 In SHIFT, each bit SHALL be sclk high for CLK_DIV cycles, then low for CLK_DIV cycles.
REQ-021 On each sclk falling edge, sdo SHALL advance to the next frame bit.
REQ-022 For reads, sdi SHALL be sampled on the last cycle of each high phase of bits 31..0 and shifted into a 32-bit capture register.
REQ-023 After bit 0's low phase, HOLD SHALL last CLK_DIV cycles with sclk=0 and sen=0.
REQ-024 At the end of HOLD, the next cycle SHALL have sen=1, busy=0, and done=1 for exactly one cycle.
REQ-025 Total busy time SHALL be 82*CLK_DIV cycles; with CLK_DIV=4, start in cycle 0 gives busy in cycles 1..328 and done in cycle 329.
REQ-026 On read completion, rdata SHALL be updated to the capture register in the same cycle as done.
REQ-027 On write completion, rdata SHALL hold its previous value.
REQ-028 A start coincident with done SHALL be accepted, giving back-to-back frames with sen high for exactly one cycle.
REQ-029 sdo SHALL be 0 whenever sen=1.
REQ-030 The half-period counter SHALL be sized for 255 and SHALL reload on every phase change.
REQ-031 The bit counter SHALL count 39 down to 0 with no wrap past 0.

Reset
REQ-032 On reset, outputs SHALL be: sen=1, sclk=0, sdo=0, busy=0, done=0, rdata=0; state=IDLE; counters=0.
REQ-033 A reset mid-frame SHALL abort the frame on the next edge: sen=1, sclk=0, no done pulse, rdata unchanged from its reset value.
REQ-034 A start asserted together with reset SHALL be ignored.

Structure
REQ-035 A shared package SHALL hold FRAME_BITS=40, HDR_BITS=8, DATA_BITS=32 and the four state encodings.
REQ-036 One sub-module, serial_tick_gen, SHALL generate half-period ticks from CLK_DIV; the shift register and FSM SHALL stay in serial_master.

Verification
REQ-037 Write, CLK_DIV=4, addr=7'h05, wdata=32'hDEADBEEF: the slave model decodes 40'h05DEADBEEF, and done arrives in cycle 329.
REQ-038 Read, addr=7'h2A, slave returns 32'hF0F0931A: the slave sees header 8'hAA, then rdata=32'hF0F0931A with done.
REQ-039 A second start at cycle 100 of an active write: the frame is unchanged and exactly one done pulse occurs.
REQ-040 Reset at cycle 150 of a read: sen=1 and sclk=0 the next cycle, no done, rdata=0.
REQ-041 start asserted in the done cycle with CLK_DIV=1: two frames, sen high for one cycle between them, busy=82 cycles each.
